mdio_master: RTL and testbench

- Clause-22 MDIO management master that drives the Ethernet PHY's PHY_MDC/PHY_MDIO pins.
- Sits between the core's PHY register-access logic and the top-level PHY_MDIO inout and PHY_MDC output.
- Accepts one read or write command at a time, serialises the 32-bit frame plus preamble, and returns read data with a no-PHY error flag.
- Tristate buffer lives at top level; this block only provides mdio_o/mdio_oe/mdio_i.

---
 rtl/mdio_master.sv | 116 +++++++++++
 tb/tb_mdio_master.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: serialises preamble plus a 32-bit frame on mdc/mdio
// and captures read data with a no-PHY flag taken from the second turnaround bit.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high, mdc parked low
// SHIFT | serialising frame bits, mdc toggling every CLK_DIV cycles
// DONE  | one-cycle completion, rd_valid pulses for reads
module mdio_master #(
  parameter int CLK_DIV = 10,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
  output logic        busy,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        rd_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int NBITS = PRE_LEN + 32;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nx;
  logic [7:0]  div_cnt;
  logic        phase;
  logic [5:0]  bits_left;
  logic [31:0] shreg;
  logic        op_write;
  logic [1:0]  mdi_sync;
  logic [14:0] rd_shift;
  logic        err_cand;
  logic        accept, bit_end, last_bit, in_pre;

  assign accept   = cmd_valid && (state == IDLE);
  // bits_left counts down from NBITS-1; values of 32 and above are preamble bits
  assign in_pre   = bits_left[5];
  assign bit_end  = (state == SHIFT) && phase && (div_cnt == 8'd0);
  assign last_bit = (bits_left == 6'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= 8'd0;
      phase     <= 1'b0;
      bits_left <= 6'd0;
      shreg     <= 32'd0;
      op_write  <= 1'b0;
      mdi_sync  <= 2'b00;
      rd_shift  <= 15'd0;
      err_cand  <= 1'b0;
      rd_data   <= 16'd0;
      rd_err    <= 1'b0;
    end else begin
      state    <= state_nx;
      mdi_sync <= {mdi_sync[0], mdio_i};
      if (accept) begin
        shreg     <= {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phyad, cmd_regad,
                      (cmd_write ? 2'b10 : 2'b11), (cmd_write ? cmd_wdata : 16'hFFFF)};
        op_write  <= cmd_write;
        div_cnt   <= 8'(CLK_DIV - 1);
        phase     <= 1'b0;
        bits_left <= 6'(NBITS - 1);
      end else if (state == SHIFT) begin
        if (div_cnt == 8'd0) begin
          div_cnt <= 8'(CLK_DIV - 1);
          phase   <= ~phase;
        end else begin
          div_cnt <= div_cnt - 8'd1;
        end
        if (bit_end) begin
          bits_left <= bits_left - 6'd1;
          if (!in_pre) shreg <= {shreg[30:0], 1'b1};
          // sample on the last high-phase cycle: bits_left 16 is TA bit 2, 15..0 are data
          if (!op_write) begin
            if (bits_left == 6'd16) err_cand <= mdi_sync[1];
            if (bits_left[5:4] == 2'b00) rd_shift <= {rd_shift[13:0], mdi_sync[1]};
            if (last_bit) begin
              rd_data <= {rd_shift, mdi_sync[1]};
              rd_err  <= err_cand;
            end
          end
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (bit_end && last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rd_valid  = (state == DONE) && !op_write;
  assign mdc       = phase;
  // reads release the line from the first turnaround bit onward
  assign mdio_oe   = (state == SHIFT) && (op_write || (bits_left > 6'd17));
  assign mdio_o    = (state != SHIFT) || in_pre || shreg[31];

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: frame table plus random commands against a bit-list frame model,
// with a PHY responder, reset abort, back-to-back and no-preamble corner cases.
module tb_mdio_master;

  localparam int DIV1 = 4;
  localparam int PRE1 = 32;
  localparam int DIV2 = 3;
  localparam int PRE2 = 0;
  localparam int NB1  = PRE1 + 32;
  localparam int NB2  = PRE2 + 32;
  localparam int LAT1 = 1 + NB1 * 2 * DIV1;
  localparam int LAT2 = 1 + NB2 * 2 * DIV2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [4:0]  cmd_phyad = 5'd0, cmd_regad = 5'd0;
  logic [15:0] cmd_wdata = 16'd0;
  logic        cmd_ready, busy, rd_valid, rd_err, mdc, mdio_o, mdio_oe;
  logic [15:0] rd_data;
  logic        mdio_i = 1'b1;

  logic        c2_valid = 1'b0, c2_write = 1'b0;
  logic [4:0]  c2_phyad = 5'd0, c2_regad = 5'd0;
  logic [15:0] c2_wdata = 16'd0;
  logic        c2_ready, c2_busy, c2_rd_valid, c2_rd_err, c2_mdc, c2_mdio_o, c2_mdio_oe;
  logic [15:0] c2_rd_data;
  logic        c2_mdio_i = 1'b1;

  mdio_master #(.CLK_DIV(DIV1), .PRE_LEN(PRE1)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad),
    .cmd_wdata(cmd_wdata), .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_err(rd_err), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i));

  mdio_master #(.CLK_DIV(DIV2), .PRE_LEN(PRE2)) u_dut_nopre (
    .clk(clk), .rst(rst), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
    .cmd_write(c2_write), .cmd_phyad(c2_phyad), .cmd_regad(c2_regad),
    .cmd_wdata(c2_wdata), .busy(c2_busy), .rd_valid(c2_rd_valid), .rd_data(c2_rd_data),
    .rd_err(c2_rd_err), .mdc(c2_mdc), .mdio_o(c2_mdio_o), .mdio_oe(c2_mdio_oe),
    .mdio_i(c2_mdio_i));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Observation of the DUT, sampled on the falling clock edge
  logic        cap_bit[$];
  logic        cap_oe[$];
  int          acc_q[$];
  int          rv_q[$];
  logic [16:0] rvd_q[$];
  int          busy_cnt = 0;
  int          glitch_cnt = 0;
  logic        p_mdc = 1'b0, p_o = 1'b1, p_oe = 1'b0, p_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mdc && !p_mdc) begin
        cap_bit.push_back(mdio_o);
        cap_oe.push_back(mdio_oe);
      end
      if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
      if (rd_valid) begin
        rv_q.push_back(cyc);
        rvd_q.push_back({rd_err, rd_data});
      end
      if (busy) busy_cnt++;
      if (((mdio_o !== p_o) || (mdio_oe !== p_oe)) && !((p_mdc && !mdc) || (busy && !p_busy)))
        glitch_cnt++;
    end
    p_mdc  = mdc;
    p_o    = mdio_o;
    p_oe   = mdio_oe;
    p_busy = busy;
  end

  logic cap2_bit[$];
  logic cap2_oe[$];
  int   acc2_q[$];
  int   busy2_cnt = 0;
  int   last_busy2 = 0;
  int   rv2_cnt = 0;
  logic p2_mdc = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (c2_mdc && !p2_mdc) begin
        cap2_bit.push_back(c2_mdio_o);
        cap2_oe.push_back(c2_mdio_oe);
      end
      if (c2_valid && c2_ready) acc2_q.push_back(cyc);
      if (c2_busy) begin
        busy2_cnt++;
        last_busy2 = cyc;
      end
      if (c2_rd_valid) rv2_cnt++;
    end
    p2_mdc = c2_mdc;
  end

  // PHY responder: changes mdio_i on mdc falls; bit n starts after n recorded rises
  int          phy_base = 0;
  logic        phy_on = 1'b0, phy_present = 1'b0;
  logic [15:0] phy_data = 16'd0;

  always @(negedge mdc) begin
    int idx;
    idx = cap_bit.size() - phy_base - PRE1;
    if (phy_on && phy_present && idx >= 14 && idx <= 31)
      mdio_i = (idx == 14) ? 1'b1 : (idx == 15) ? 1'b0 : phy_data[31 - idx];
    else
      mdio_i = 1'b1;
  end

  // Reference frame: list of (bit, drive-enable) per mdc rise
  logic exp_bit[$];
  logic exp_oe[$];

  task automatic add_field(input logic [15:0] v, input int n, input logic oe);
    for (int i = n - 1; i >= 0; i--) begin
      exp_bit.push_back(v[i]);
      exp_oe.push_back(oe);
    end
  endtask

  task automatic build_exp(input int pre, input logic wr, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [15:0] wd);
    exp_bit.delete();
    exp_oe.delete();
    for (int i = 0; i < pre; i++) add_field(16'h1, 1, 1'b1);
    add_field(16'h1, 2, 1'b1);
    add_field(wr ? 16'h1 : 16'h2, 2, 1'b1);
    add_field({11'd0, phy}, 5, 1'b1);
    add_field({11'd0, rg}, 5, 1'b1);
    if (wr) begin
      add_field(16'h2, 2, 1'b1);
      add_field(wd, 16, 1'b1);
    end else begin
      add_field(16'h0, 2, 1'b0);
      add_field(16'h0, 16, 1'b0);
    end
  endtask

  task automatic cmp_frame(input string nm, input int which, input int base);
    int bad_b, bad_o, n;
    logic b, o;
    bad_b = 0;
    bad_o = 0;
    n = (which == 1) ? cap_bit.size() : cap2_bit.size();
    for (int i = 0; i < exp_bit.size(); i++) begin
      if (base + i >= n) begin
        bad_b++;
        bad_o++;
      end else begin
        if (which == 1) begin
          b = cap_bit[base + i];
          o = cap_oe[base + i];
        end else begin
          b = cap2_bit[base + i];
          o = cap2_oe[base + i];
        end
        if (o !== exp_oe[i]) bad_o++;
        if (exp_oe[i] && (b !== exp_bit[i])) bad_b++;
      end
    end
    chk({nm, " frame_bits"}, 32'(bad_b), 32'd0);
    chk({nm, " frame_oe"}, 32'(bad_o), 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wd;
    logic        present;
    logic [15:0] pdata;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                              input logic [15:0] wd, input logic present, input logic [15:0] pdata);
    vec_t v;
    v.wr = wr; v.phy = phy; v.rg = rg; v.wd = wd; v.present = present; v.pdata = pdata;
    v.exp_data = present ? pdata : 16'hFFFF;
    v.exp_err  = !present;
    return v;
  endfunction

  logic [15:0] last_rd = 16'd0;
  logic        last_err = 1'b0;

  task automatic run_frame(input string nm, input vec_t v);
    int b_cap, b_acc, b_rv, b_busy, k;
    b_cap = cap_bit.size(); b_acc = acc_q.size(); b_rv = rv_q.size(); b_busy = busy_cnt;
    phy_base = b_cap; phy_on = !v.wr; phy_present = v.present; phy_data = v.pdata;
    build_exp(PRE1, v.wr, v.phy, v.rg, v.wd);
    @(posedge clk); #2;
    cmd_write = v.wr; cmd_phyad = v.phy; cmd_regad = v.rg; cmd_wdata = v.wd; cmd_valid = 1'b1;
    k = 0;
    while (acc_q.size() == b_acc && k < 50) begin @(posedge clk); #2; k++; end
    cmd_valid = 1'b0;
    k = 0;
    while (busy && k < 2000) begin @(posedge clk); #2; k++; end
    chk({nm, " accepted"}, 32'(acc_q.size() - b_acc), 32'd1);
    chk({nm, " finished"}, 32'(busy), 32'd0);
    chk({nm, " nbits"}, 32'(cap_bit.size() - b_cap), 32'(NB1));
    cmp_frame(nm, 1, b_cap);
    chk({nm, " busy_cycles"}, 32'(busy_cnt - b_busy), 32'(LAT1));
    chk({nm, " rd_valid_count"}, 32'(rv_q.size() - b_rv), v.wr ? 32'd0 : 32'd1);
    if (!v.wr) begin
      last_rd = v.exp_data;
      last_err = v.exp_err;
      if (rv_q.size() > b_rv && acc_q.size() > b_acc) begin
        chk({nm, " rd_valid_latency"}, 32'(rv_q[b_rv] - acc_q[b_acc]), 32'(LAT1));
        chk({nm, " rd_at_valid"}, 32'(rvd_q[b_rv]), 32'({v.exp_err, v.exp_data}));
      end
    end
    chk({nm, " rd_data_held"}, 32'(rd_data), 32'(last_rd));
    chk({nm, " rd_err_held"}, 32'(rd_err), 32'(last_err));
  endtask

  vec_t vecs[11];

  initial begin
    int b_cap, b_acc, b_rv, b_busy, k, gap_n, gap_bad;
    logic sw;

    vecs[0] = mk(1'b1, 5'h01, 5'h00, 16'h1200, 1'b0, 16'h0000);
    vecs[1] = mk(1'b0, 5'h1F, 5'h02, 16'h0000, 1'b1, 16'h0022);
    vecs[2] = mk(1'b0, 5'h05, 5'h07, 16'h0000, 1'b0, 16'h0000);
    vecs[3] = mk(1'b1, 5'h1F, 5'h1F, 16'hFFFF, 1'b0, 16'h0000);
    vecs[4] = mk(1'b0, 5'h0A, 5'h15, 16'h0000, 1'b1, 16'hA5C3);
    vecs[5] = mk(1'b1, 5'h00, 5'h00, 16'h0000, 1'b0, 16'h0000);
    for (int i = 6; i < 11; i++)
      vecs[i] = mk(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                   1'($urandom_range(0, 3) != 0), 16'($urandom));

    repeat (3) @(negedge clk);
    chk("reset outputs", 32'({mdc, mdio_o, mdio_oe, cmd_ready, busy, rd_valid, rd_err, rd_data}),
        32'({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));
    chk("reset outputs nopre", 32'({c2_mdc, c2_mdio_o, c2_mdio_oe, c2_ready, c2_busy, c2_rd_valid}),
        32'({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}));
    @(posedge clk); #2;
    rst = 1'b0;

    // Reset at bit 40 of a read abandons the frame silently
    b_cap = cap_bit.size(); b_rv = rv_q.size();
    phy_base = b_cap; phy_on = 1'b1; phy_present = 1'b1; phy_data = 16'hBEEF;
    @(posedge clk); #2;
    cmd_write = 1'b0; cmd_phyad = 5'h03; cmd_regad = 5'h04; cmd_valid = 1'b1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    k = 0;
    while (cap_bit.size() - b_cap < 40 && k < 2000) begin @(posedge clk); #2; k++; end
    chk("abort reached bit 40", 32'(cap_bit.size() - b_cap), 32'd40);
    rst = 1'b1;
    #1;
    chk("abort outputs", 32'({mdc, mdio_o, mdio_oe, cmd_ready, busy, rd_valid, rd_err, rd_data}),
        32'({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (600) @(posedge clk);
    #2;
    chk("abort no rd_valid", 32'(rv_q.size() - b_rv), 32'd0);
    chk("abort rd_data", 32'(rd_data), 32'h0000);

    for (int i = 0; i < 11; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

    // Two queued writes with cmd_valid held high
    b_cap = cap_bit.size(); b_acc = acc_q.size(); b_rv = rv_q.size(); b_busy = busy_cnt;
    phy_on = 1'b0;
    gap_n = 0; gap_bad = 0; sw = 1'b0;
    @(posedge clk); #2;
    cmd_write = 1'b1; cmd_phyad = 5'h02; cmd_regad = 5'h03; cmd_wdata = 16'h5A5A; cmd_valid = 1'b1;
    k = 0;
    while (acc_q.size() - b_acc < 2 && k < 1500) begin
      @(posedge clk); #2; k++;
      if (acc_q.size() - b_acc == 1) begin
        if (!sw) begin
          cmd_phyad = 5'h10; cmd_regad = 5'h1F; cmd_wdata = 16'h0F0F; sw = 1'b1;
        end
        if (cyc == acc_q[b_acc] + LAT1 || cyc == acc_q[b_acc] + LAT1 + 1) begin
          gap_n++;
          if (mdc !== 1'b0) gap_bad++;
        end
      end
    end
    cmd_valid = 1'b0;
    k = 0;
    while (busy && k < 2000) begin @(posedge clk); #2; k++; end
    chk("b2b accepts", 32'(acc_q.size() - b_acc), 32'd2);
    if (acc_q.size() - b_acc == 2)
      chk("b2b accept spacing", 32'(acc_q[b_acc + 1] - acc_q[b_acc]), 32'(LAT1 + 1));
    chk("b2b gap samples", 32'(gap_n), 32'd2);
    chk("b2b gap mdc low", 32'(gap_bad), 32'd0);
    chk("b2b nbits", 32'(cap_bit.size() - b_cap), 32'(2 * NB1));
    build_exp(PRE1, 1'b1, 5'h02, 5'h03, 16'h5A5A);
    cmp_frame("b2b first", 1, b_cap);
    build_exp(PRE1, 1'b1, 5'h10, 5'h1F, 16'h0F0F);
    cmp_frame("b2b second", 1, b_cap + NB1);
    chk("b2b busy_cycles", 32'(busy_cnt - b_busy), 32'(2 * LAT1));
    chk("b2b no rd_valid", 32'(rv_q.size() - b_rv), 32'd0);
    chk("b2b rd_data held", 32'({rd_err, rd_data}), 32'({last_err, last_rd}));

    // No-preamble instance, CLK_DIV=3
    b_cap = cap2_bit.size(); b_acc = acc2_q.size(); b_busy = busy2_cnt;
    build_exp(PRE2, 1'b1, 5'h05, 5'h11, 16'h8001);
    @(posedge clk); #2;
    c2_write = 1'b1; c2_phyad = 5'h05; c2_regad = 5'h11; c2_wdata = 16'h8001; c2_valid = 1'b1;
    k = 0;
    while (acc2_q.size() == b_acc && k < 50) begin @(posedge clk); #2; k++; end
    c2_valid = 1'b0;
    k = 0;
    while (c2_busy && k < 1000) begin @(posedge clk); #2; k++; end
    chk("nopre accepted", 32'(acc2_q.size() - b_acc), 32'd1);
    chk("nopre nbits", 32'(cap2_bit.size() - b_cap), 32'(NB2));
    if (cap2_bit.size() > b_cap) chk("nopre first bit", 32'(cap2_bit[b_cap]), 32'd0);
    cmp_frame("nopre", 2, b_cap);
    chk("nopre busy_cycles", 32'(busy2_cnt - b_busy), 32'(LAT2));
    if (acc2_q.size() > b_acc) chk("nopre done cycle", 32'(last_busy2 - acc2_q[b_acc]), 32'(LAT2));
    chk("nopre no rd_valid", 32'(rv2_cnt), 32'd0);
    chk("nopre rd held", 32'({c2_rd_err, c2_rd_data}), 32'd0);

    chk("mdio changes only at bit start", 32'(glitch_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
